// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one registered output stream.
// Define STREAM_ARB_PRIO0_EN to give source 0 absolute priority at each arbitration.
module stream_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 2,
    parameter int NUM_SRC    = 4
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_SRC-1:0]               src_t_valid,
    output logic [NUM_SRC-1:0]               src_t_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]    src_t_data,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]  src_t_strb,
    input  logic [NUM_SRC*DATA_WIDTH/8-1:0]  src_t_keep,
    input  logic [NUM_SRC-1:0]               src_t_last,
    input  logic [NUM_SRC*USER_WIDTH-1:0]    src_t_user,
    output logic                             dst_t_valid,
    input  logic                             dst_t_ready,
    output logic [DATA_WIDTH-1:0]            dst_t_data,
    output logic [DATA_WIDTH/8-1:0]          dst_t_strb,
    output logic [DATA_WIDTH/8-1:0]          dst_t_keep,
    output logic                             dst_t_last,
    output logic [USER_WIDTH-1:0]            dst_t_user,
    output logic [DEST_WIDTH-1:0]            dst_t_dest,
    output logic [$clog2(NUM_SRC)-1:0]       grant_idx,
    output logic                             busy
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int KW = DATA_WIDTH / 8;

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [KW-1:0]           strb_q, strb_d;
    logic [KW-1:0]           keep_q, keep_d;
    logic                    last_q, last_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;
    logic [DEST_WIDTH-1:0]   dest_q, dest_d;

    logic [GW-1:0]           ptr;
    logic [GW-1:0]           cand;
    logic [GW-1:0]           pick_idx;
    logic                    pick_found;
    logic                    can_acc;
    logic                    accept;

`ifdef STREAM_ARB_PRIO0_EN
    logic [GW-1:0]           ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = grant_q;
`endif

    // Scan upward from the pointer with wrap; first valid source wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
`ifdef STREAM_ARB_PRIO0_EN
        if (src_t_valid[0]) begin
            pick_found = 1'b1;
        end
`endif
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = GW'((int'(ptr) + i) % NUM_SRC);
`ifdef STREAM_ARB_PRIO0_EN
            if (!pick_found && cand != '0 && src_t_valid[cand]) begin
`else
            if (!pick_found && src_t_valid[cand]) begin
`endif
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign can_acc = !valid_q || dst_t_ready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        src_t_ready = '0;
        accept      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                src_t_ready[grant_q] = can_acc;
                accept = can_acc && src_t_valid[grant_q];
                if (accept && src_t_last[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef STREAM_ARB_PRIO0_EN
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && pick_found && pick_idx != '0) begin
            ptr_d = pick_idx;
        end
    end
`endif

    // Output slice: drain and reload in the same cycle keeps full rate.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        strb_d  = strb_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        dest_d  = dest_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = src_t_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            strb_d  = src_t_strb[int'(grant_q)*KW +: KW];
            keep_d  = src_t_keep[int'(grant_q)*KW +: KW];
            last_d  = src_t_last[grant_q];
            user_d  = src_t_user[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
            dest_d  = DEST_WIDTH'(grant_q);
        end else if (dst_t_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            grant_q <= GW'(NUM_SRC - 1);
            valid_q <= 1'b0;
            data_q  <= '0;
            strb_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
            dest_q  <= dest_d;
        end
    end

`ifdef STREAM_ARB_PRIO0_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q <= GW'(NUM_SRC - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign dst_t_valid = valid_q;
    assign dst_t_data  = data_q;
    assign dst_t_strb  = strb_q;
    assign dst_t_keep  = keep_q;
    assign dst_t_last  = last_q;
    assign dst_t_user  = user_q;
    assign dst_t_dest  = dest_q;
    assign grant_idx   = grant_q;
    assign busy        = (state_q == S_LOCK);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: cycle table, directed corners, random vs queue model.
// Honours STREAM_ARB_PRIO0_EN for the expected arbitration order.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] strb;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
        logic [1:0]    dest;
    } beat_t;

    typedef struct {
        logic [N-1:0] valid;
        logic         dready;
        logic         ev;
        logic [1:0]   ed;
        logic         eb;
        logic [N-1:0] er;
        logic         el;
    } vec_t;

    logic              aclk;
    logic              aresetn;
    logic [N-1:0]      src_t_valid;
    logic [N-1:0]      src_t_ready;
    logic [N*DW-1:0]   src_t_data;
    logic [N*KW-1:0]   src_t_strb;
    logic [N*KW-1:0]   src_t_keep;
    logic [N-1:0]      src_t_last;
    logic [N-1:0]      src_t_user;
    logic              dst_t_valid;
    logic              dst_t_ready;
    logic [DW-1:0]     dst_t_data;
    logic [KW-1:0]     dst_t_strb;
    logic [KW-1:0]     dst_t_keep;
    logic              dst_t_last;
    logic [0:0]        dst_t_user;
    logic [1:0]        dst_t_dest;
    logic [1:0]        grant_idx;
    logic              busy;

    stream_rr_arbiter #(
        .DATA_WIDTH(DW), .USER_WIDTH(1), .DEST_WIDTH(2), .NUM_SRC(N)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .src_t_valid(src_t_valid), .src_t_ready(src_t_ready),
        .src_t_data(src_t_data), .src_t_strb(src_t_strb),
        .src_t_keep(src_t_keep), .src_t_last(src_t_last),
        .src_t_user(src_t_user),
        .dst_t_valid(dst_t_valid), .dst_t_ready(dst_t_ready),
        .dst_t_data(dst_t_data), .dst_t_strb(dst_t_strb),
        .dst_t_keep(dst_t_keep), .dst_t_last(dst_t_last),
        .dst_t_user(dst_t_user), .dst_t_dest(dst_t_dest),
        .grant_idx(grant_idx), .busy(busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int           n_chk;
    int           n_fail;
    beat_t        sq[N][$];
    beat_t        exp_q[$];
    int           dseq[$];
    int           out_cnt[N];
    logic [N-1:0] hold;
    logic         dready;
    logic [N-1:0] hs;
    logic         m_locked;
    int           m_owner;
    int           m_ptr;
    logic         lat_pend;
    logic         stall_pend;
    logic [127:0] stall_snap;
    vec_t         tv[16];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Arbitration rule: scan from the last winner upward with wrap.
    function automatic int pick(input logic [N-1:0] v);
        int w;
        w = -1;
`ifdef STREAM_ARB_PRIO0_EN
        if (v[0]) w = 0;
        for (int k = 1; k <= N && w < 0; k++)
            if ((m_ptr + k) % N != 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w != 0) m_ptr = w;
`else
        for (int k = 1; k <= N && w < 0; k++)
            if (v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        m_ptr = w;
`endif
        return w;
    endfunction

    function automatic beat_t cur_out();
        beat_t b;
        b.data = dst_t_data;
        b.strb = dst_t_strb;
        b.keep = dst_t_keep;
        b.last = dst_t_last;
        b.user = dst_t_user[0];
        b.dest = dst_t_dest;
        return b;
    endfunction

    task automatic add_pkt(input int s, input int n, input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = base + DW'(k);
            b.strb = KW'($urandom);
            b.keep = '1;
            b.last = (k == n - 1);
            b.user = 1'(k);
            b.dest = 2'(s);
            sq[s].push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b = '0;
            src_t_valid[i] = 1'b0;
            if (sq[i].size() > 0) begin
                b = sq[i][0];
                src_t_valid[i] = !hold[i];
            end
            src_t_data[i*DW +: DW] = b.data;
            src_t_strb[i*KW +: KW] = b.strb;
            src_t_keep[i*KW +: KW] = b.keep;
            src_t_last[i] = b.last;
            src_t_user[i] = b.user;
        end
        dst_t_ready = dready;
    endtask

    task automatic monitor();
        beat_t        act;
        beat_t        e;
        logic [N-1:0] others;
        if (lat_pend) chk("latency", dst_t_valid, 1);
        if (stall_pend) chk("stall_hold", {dst_t_valid, cur_out()}, stall_snap);
        if (dst_t_valid && dst_t_ready) begin
            act = cur_out();
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_beat: got %h expected none", act);
            end else begin
                e = exp_q.pop_front();
                chk("dst_beat", act, e);
                dseq.push_back(int'(act.dest));
                out_cnt[act.dest]++;
            end
        end
        stall_pend = dst_t_valid && !dst_t_ready;
        stall_snap = {dst_t_valid, cur_out()};
        lat_pend = 1'b0;
        chk("busy", busy, m_locked);
        if (!m_locked) begin
            chk("idle_ready", src_t_ready, 0);
            if (|src_t_valid) begin
                m_owner = pick(src_t_valid);
                m_locked = 1'b1;
            end
        end else begin
            chk("grant", grant_idx, m_owner);
            others = src_t_ready;
            others[m_owner] = 1'b0;
            chk("ready_others", others, 0);
            chk("ready_owner", src_t_ready[m_owner], !dst_t_valid || dst_t_ready);
            if (src_t_valid[m_owner] && src_t_ready[m_owner]) begin
                e = sq[m_owner][0];
                e.dest = 2'(m_owner);
                exp_q.push_back(e);
                lat_pend = 1'b1;
                if (e.last) m_locked = 1'b0;
            end
        end
    endtask

    // One clock: retire handshakes, drive after the edge, check at negedge.
    task automatic step();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++)
            if (hs[i]) void'(sq[i].pop_front());
        drive();
        @(negedge aclk);
        hs = src_t_valid & src_t_ready;
        monitor();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            sq[i].delete();
            out_cnt[i] = 0;
        end
        hold = '0;
        dready = 1'b1;
        drive();
        exp_q.delete();
        dseq.delete();
        hs = '0;
        m_locked = 1'b0;
        m_ptr = N - 1;
        lat_pend = 1'b0;
        stall_pend = 1'b0;
        repeat (2) @(negedge aclk);
        chk("rst_dvalid", dst_t_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_idx, N - 1);
        chk("rst_ready", src_t_ready, 0);
        chk("rst_out", {dst_t_last, cur_out()}, 0);
        aresetn = 1'b1;
    endtask

    function automatic vec_t mk(input logic ev, input logic [1:0] ed,
                                input logic eb, input logic [N-1:0] er,
                                input logic el);
        vec_t v;
        v.valid = '1;
        v.dready = 1'b1;
        v.ev = ev;
        v.ed = ed;
        v.eb = eb;
        v.er = er;
        v.el = el;
        return v;
    endfunction

    initial begin
        n_chk = 0;
        n_fail = 0;
        src_t_valid = '0;
        src_t_data = '0;
        src_t_strb = '0;
        src_t_keep = '0;
        src_t_last = '0;
        src_t_user = '0;
        dst_t_ready = 1'b1;
        aresetn = 1'b1;

        // All four sources sending 2-beat packets back to back.
        tv[0]  = mk(0, 0, 0, 4'b0000, 0);
        tv[1]  = mk(0, 0, 1, 4'b0001, 0);
        tv[2]  = mk(1, 0, 1, 4'b0001, 0);
        tv[3]  = mk(1, 0, 0, 4'b0000, 1);
        tv[4]  = mk(0, 0, 1, 4'b0010, 0);
        tv[5]  = mk(1, 1, 1, 4'b0010, 0);
        tv[6]  = mk(1, 1, 0, 4'b0000, 1);
        tv[7]  = mk(0, 0, 1, 4'b0100, 0);
        tv[8]  = mk(1, 2, 1, 4'b0100, 0);
        tv[9]  = mk(1, 2, 0, 4'b0000, 1);
        tv[10] = mk(0, 0, 1, 4'b1000, 0);
        tv[11] = mk(1, 3, 1, 4'b1000, 0);
        tv[12] = mk(1, 3, 0, 4'b0000, 1);
        tv[13] = mk(0, 0, 1, 4'b0001, 0);
        tv[14] = mk(1, 0, 1, 4'b0001, 0);
        tv[15] = mk(1, 0, 0, 4'b0000, 1);

        // Source 2, three beats.
        do_reset();
        add_pkt(2, 3, 64'hA0);
        step();
        chk("t1_c0_dvalid", dst_t_valid, 0);
        step();
        chk("t1_c1_dvalid", dst_t_valid, 0);
        step();
        chk("t1_c2_dvalid", dst_t_valid, 1);
        chk("t1_c2_data", dst_t_data, 64'hA0);
        chk("t1_c2_dest", dst_t_dest, 2);
        step();
        chk("t1_c3_busy", busy, 1);
        step();
        chk("t1_c4_busy", busy, 0);
        repeat (3) step();
        chk("t1_count", out_cnt[2], 3);

        // Cycle table.
        do_reset();
        for (int s = 0; s < N; s++)
            for (int p = 0; p < 5; p++)
                add_pkt(s, 2, 64'(s * 256 + p * 2));
        for (int c = 0; c < 16; c++) begin
            hold = ~tv[c].valid;
            dready = tv[c].dready;
            step();
            chk("tbl_dvalid", dst_t_valid, tv[c].ev);
            chk("tbl_busy", busy, tv[c].eb);
            chk("tbl_ready", src_t_ready, tv[c].er);
            if (tv[c].ev) begin
                chk("tbl_dest", dst_t_dest, tv[c].ed);
                chk("tbl_last", dst_t_last, tv[c].el);
            end
        end

        // Downstream stall mid-packet from source 1.
        do_reset();
        add_pkt(1, 4, 64'hB0);
        repeat (3) step();
        dready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_ready1", src_t_ready[1], 0);
            chk("stall_data", {dst_t_valid, dst_t_data}, {1'b1, 64'hB1});
        end
        dready = 1'b1;
        repeat (10) step();
        chk("stall_count", out_cnt[1], 4);
        chk("stall_drained", exp_q.size(), 0);

        // Source 3 pauses mid-packet while source 0 waits.
        do_reset();
        add_pkt(3, 3, 64'hC0);
        add_pkt(0, 2, 64'hD0);
        hold[0] = 1'b1;
        repeat (2) step();
        hold = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("pause_grant", grant_idx, 3);
            chk("pause_busy", busy, 1);
            chk("pause_ready0", src_t_ready[0], 0);
        end
        hold = '0;
        repeat (15) step();
        chk("pause_len", dseq.size(), 5);
        if (dseq.size() == 5) begin
            for (int k = 0; k < 5; k++)
                chk("pause_order", dseq[k], (k < 3) ? 3 : 0);
        end

        // Asynchronous reset mid-packet.
        do_reset();
        add_pkt(1, 4, 64'hE0);
        repeat (3) step();
        #2;
        aresetn = 1'b0;
        #1;
        chk("arst_dvalid", dst_t_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", src_t_ready, 0);
        do_reset();
        add_pkt(1, 1, 64'hE8);
        add_pkt(2, 1, 64'hF0);
        repeat (2) step();
        chk("arst_first_grant", grant_idx, 1);
        repeat (6) step();

        // Sources 0 and 1 with single-beat packets.
        do_reset();
        for (int p = 0; p < 6; p++) begin
            add_pkt(0, 1, 64'(p));
            add_pkt(1, 1, 64'(16 + p));
        end
        repeat (14) step();
        chk("prio_len_ok", dseq.size() >= 4, 1);
        if (dseq.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
`ifdef STREAM_ARB_PRIO0_EN
                chk("prio_dest", dseq[k], 0);
`else
                chk("alt_dest", dseq[k], k % 2);
`endif
            end
        end

        // Random traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int s = 0; s < N; s++) begin
                if (sq[s].size() < 3 && $urandom_range(7) == 0)
                    add_pkt(s, int'($urandom_range(4, 1)), {$urandom, $urandom});
                hold[s] = ($urandom_range(4) == 0);
            end
            dready = ($urandom_range(9) < 7);
            step();
        end
        hold = '0;
        dready = 1'b1;
        repeat (300) step();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_src_empty",
            sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one downstream stream processor (e.g. a YUV422-to-444 converter) between NUM_SRC upstream video streams.
- A grant is held from the first beat of a packet until its t_last beat.
- Each output beat is tagged on t_dest with the index of the winning source, so the crossbar can route results back.
- Sits between the DMA read channels and the shared format-conversion stage.

Parameters:
- DATA_WIDTH, 64, stream data width in bits (multiple of 8).
- USER_WIDTH, 1, t_user width, passed through unchanged.
- DEST_WIDTH, 2, t_dest width; must be >= clog2(NUM_SRC).
- NUM_SRC, 4, number of requesting streams (2..8).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- src_t_valid  in  NUM_SRC  per-source valid
- src_t_ready  out  NUM_SRC  per-source ready
- src_t_data  in  NUM_SRC*DATA_WIDTH  source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- src_t_strb  in  NUM_SRC*DATA_WIDTH/8  per-source strobes
- src_t_keep  in  NUM_SRC*DATA_WIDTH/8  per-source keeps
- src_t_last  in  NUM_SRC  per-source end of packet
- src_t_user  in  NUM_SRC*USER_WIDTH  per-source user
- dst_t_valid  out  1  registered output valid
- dst_t_ready  in  1  downstream ready
- dst_t_data  out  DATA_WIDTH  registered data
- dst_t_strb  out  DATA_WIDTH/8  registered strobes
- dst_t_keep  out  DATA_WIDTH/8  registered keeps
- dst_t_last  out  1  registered last
- dst_t_user  out  USER_WIDTH  registered user
- dst_t_dest  out  DEST_WIDTH  zero-extended index of the source that produced the beat
- grant_idx  out  clog2(NUM_SRC)  current or most recent grant
- busy  out  1  high while a packet is locked

Behaviour:
Reset:
- aclk and async active-low aresetn; all state is cleared asynchronously when aresetn is asserted.
- Reset values: dst_t_valid=0, dst_t_last=0, dst_t_dest=0, dst_t_data/strb/keep/user=0, src_t_ready=0, busy=0, grant_idx=NUM_SRC-1. Arbitration therefore starts from source 0.
- Reset mid-packet drops the packet. No partial beat is output after reset release.

State machine:
- IDLE: src_t_ready=0. If any src_t_valid is high, select the first valid source scanning (grant_idx+1) mod NUM_SRC upward with wrap. At the clock edge, register grant_idx and go to LOCK with busy=1. Arbitration decision costs exactly 1 cycle.
- LOCK: src_t_ready[grant_idx] = !dst_t_valid || dst_t_ready. All other ready bits are 0.
  - An accepted beat (valid and ready) loads the dst registers next edge and sets dst_t_valid=1, dst_t_dest=grant_idx.
  - If the accepted beat has t_last=1, return to IDLE with busy=0.
- Output register: if dst_t_valid && dst_t_ready and no new beat is accepted, clear dst_t_valid. Simultaneous drain and accept keeps dst_t_valid=1 with the new beat, giving full throughput within a packet.

Timing and ordering:
- Latency from src beat acceptance to dst_t_valid: 1 cycle.
- First beat of a packet: src valid at cycle 0, grant at edge 1, accepted in cycle 1, dst valid in cycle 2.
- Bubble between packets: 1 IDLE cycle.
- Beats from different sources are never interleaved. Packet order within a source is preserved.
- A source that drops t_valid mid-packet keeps the lock. The arbiter waits indefinitely; there is no timeout.

Boundary conditions:
- A single-beat packet (t_last on the first beat) returns to IDLE after one accept.
- With all sources continuously valid, grants rotate 0,1,2,3,0,...
- With only one source valid, it is re-granted after each 1-cycle IDLE gap.
- Downstream stall (dst_t_ready=0 with dst_t_valid=1) forces src_t_ready=0. The dst registers hold stable, per the stream rule.

Optional Feature:
- Macro: STREAM_ARB_PRIO0_EN.
- Defined: in IDLE, source 0 wins whenever src_t_valid[0]=1, regardless of grant_idx. The remaining sources are round-robin among themselves; the pointer advances only on non-zero grants. Locking is unchanged, so source 0 never preempts a packet in progress.
- Undefined: pure round-robin as described above.

Test Plan:
- Reset, then source 2 sends 3 beats (data 0xA0,0xA1,0xA2, last on third) -> dst shows the same 3 beats with t_dest=2; first dst_t_valid 2 cycles after src valid; busy falls after the third accept.
- All 4 sources continuously send 2-beat packets -> dst t_dest sequence 0,0,1,1,2,2,3,3,0,0; no interleaving; exactly 1 idle cycle between packets.
- Hold dst_t_ready=0 for 5 cycles mid-packet from source 1 -> dst_t_data/t_valid stable; src_t_ready[1]=0 throughout; no beat lost or duplicated after release.
- Source 3 drops t_valid for 4 cycles mid-packet while source 0 is valid -> grant stays 3; source 0 starts only after source 3's t_last beat.
- Assert aresetn=0 mid-packet -> dst_t_valid=0 and busy=0 immediately (asynchronously); after release, the first grant goes to the lowest valid index.
- With STREAM_ARB_PRIO0_EN, sources 0 and 1 continuously valid with 1-beat packets -> t_dest always 0; without the macro -> t_dest alternates 0,1.
